// File: rtl/demux_1to8_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1to8_reg_if
//  Purpose  : Bundle for the 1-to-8 demux. It carries the input word stream,
//             the lane select/mode controls, the eight output lanes and
//             their handshakes, and the status counters.
//  Revision : 1.0 - initial release
// ============================================================================
interface demux_1to8_reg_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) ();

  logic [DATA_W-1:0]   data_in;
  logic [2:0]          selection_in;
  logic                in_valid;
  logic                in_ready;
  logic                auto_mode;
  logic [8*DATA_W-1:0] demux_out;
  logic [7:0]          out_valid;
  logic [7:0]          out_ready;
  logic [2:0]          seq_cnt;
  logic [CNT_W-1:0]    xfer_count;

  // Demux side: it consumes the input stream and drives the lanes.
  modport slave (
    input  data_in, selection_in, in_valid, auto_mode, out_ready,
    output in_ready, demux_out, out_valid, seq_cnt, xfer_count
  );

  // Producer/consumer side: it feeds words and drains the lanes.
  modport master (
    output data_in, selection_in, in_valid, auto_mode, out_ready,
    input  in_ready, demux_out, out_valid, seq_cnt, xfer_count
  );

endinterface
`default_nettype wire

// File: rtl/demux_1to8_reg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1to8_reg
//  Purpose  : Clocked 1-to-8 demultiplexer. Each output lane has a 1-deep
//             register with a valid/ready handshake. The target lane comes
//             either from selection_in or, in auto mode, from a wrapping
//             sequence counter that de-interleaves a TDM stream.
//  Revision : 1.0 - initial release
// ============================================================================
module demux_1to8_reg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  demux_1to8_reg_if.slave       bus
);

  logic [DATA_W-1:0] r_data [8];
  logic [7:0]        r_valid;
  logic [2:0]        r_seq;
  logic [CNT_W-1:0]  r_xfer;

  logic [2:0]        w_sel_eff;
  logic [7:0]        w_lane_free;
  logic              w_in_ready;
  logic              w_accept;
  logic [7:0]        w_load;

  // The mode switch takes effect in the same cycle; there is no registered
  // copy of the selection.
  assign w_sel_eff   = bus.auto_mode ? r_seq : bus.selection_in;

  // A lane being popped this cycle counts as free, so it can be refilled
  // back-to-back without a bubble.
  assign w_lane_free = ~r_valid | bus.out_ready;

  // Holding ready low during reset keeps the producer from believing a word
  // was taken while the registers are being cleared.
  assign w_in_ready  = rst_n & w_lane_free[w_sel_eff];
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_load      = w_accept ? (8'd1 << w_sel_eff) : 8'd0;

  // Per-lane data registers hold their last word after a pop; only reset
  // clears them.
  for (genvar i = 0; i < 8; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data[i] <= '0;
      end else if (w_load[i]) begin
        r_data[i] <= bus.data_in;
      end
    end

    assign bus.demux_out[i*DATA_W +: DATA_W] = r_data[i];
  end

  // Pops clear valid; a load in the same cycle wins and keeps the lane full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 8'h00;
    end else begin
      r_valid <= (r_valid & ~bus.out_ready) | w_load;
    end
  end

  // The sequence counter only advances on words taken in auto mode; the
  // 3-bit width gives the 7->0 wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= 3'd0;
    end else if (w_accept && bus.auto_mode) begin
      r_seq <= r_seq + 3'd1;
    end
  end

  // Accepted-word counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer <= '0;
    end else if (w_accept && (r_xfer != {CNT_W{1'b1}})) begin
      r_xfer <= r_xfer + 1'b1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_valid;
  assign bus.seq_cnt    = r_seq;
  assign bus.xfer_count = r_xfer;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to8_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1to8_reg
//  Purpose  : Self-checking bench for demux_1to8_reg. A behavioural model of
//             the lanes, sequence counter and transfer counter predicts
//             every output; directed scenarios are followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to8_reg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  demux_1to8_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  demux_1to8_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_data [8];
  bit         m_valid [8];
  int         m_seq;
  int         m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_data[i]  = 8'h00;
      m_valid[i] = 1'b0;
    end
    m_seq = 0;
    m_cnt = 0;
  endfunction

  function automatic logic [63:0] m_out();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_data[i];
    return v;
  endfunction

  function automatic logic [7:0] m_vmask();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic int target();
    return bus.auto_mode ? m_seq : int'(bus.selection_in);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare everything mid-cycle, then advance the model at the edge.
  task automatic tick(output bit acc);
    int t;
    bit rdy;
    @(negedge clk);
    t   = target();
    rdy = !m_valid[t] || bus.out_ready[t];
    chk("in_ready",   64'(bus.in_ready),   64'(rdy));
    chk("out_valid",  64'(bus.out_valid),  64'(m_vmask()));
    chk("demux_out",  bus.demux_out,       m_out());
    chk("seq_cnt",    64'(bus.seq_cnt),    64'(m_seq));
    chk("xfer_count", 64'(bus.xfer_count), 64'(m_cnt));
    acc = bus.in_valid && rdy;
    @(posedge clk);
    for (int i = 0; i < 8; i++)
      if (m_valid[i] && bus.out_ready[i]) m_valid[i] = 1'b0;
    if (acc) begin
      m_data[t]  = bus.data_in;
      m_valid[t] = 1'b1;
      if (bus.auto_mode) m_seq = (m_seq + 1) % 8;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(acc);
  endtask

  // Present a word and hold it until it is taken (bounded).
  task automatic send(input logic [7:0] d, input logic [2:0] sel, input logic auto);
    bit acc;
    int n;
    bus.data_in      = d;
    bus.selection_in = sel;
    bus.auto_mode    = auto;
    bus.in_valid     = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),   64'(0));
    chk("rst_out_valid", 64'(bus.out_valid),  64'(0));
    chk("rst_xfer",      64'(bus.xfer_count), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    bus.data_in      = '0;
    bus.selection_in = '0;
    bus.in_valid     = 1'b0;
    bus.auto_mode    = 1'b0;
    bus.out_ready    = 8'hFF;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Explicit mode, all lanes ready
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 3'(i), 1'b0);
    idle(1);
    chk("explicit_xfer8", 64'(bus.xfer_count), 64'(8));

    // Backpressure on lane 3, then release: refill coincides with the pop
    bus.out_ready = 8'hF7;
    send(8'h11, 3'd3, 1'b0);
    bus.data_in = 8'h22;
    bus.in_valid = 1'b1;
    idle(3);
    chk("bp_lane3_hold", 64'(bus.demux_out[24 +: 8]), 64'(8'h11));
    bus.out_ready = 8'hFF;
    send(8'h22, 3'd3, 1'b0);
    chk("bp_lane3_valid", 64'(bus.out_valid[3]), 64'(1));
    chk("bp_lane3_new",   64'(bus.demux_out[24 +: 8]), 64'(8'h22));
    idle(2);

    // Auto mode, 10 words wrap back over lanes 0 and 1
    for (int i = 0; i < 10; i++) send(8'(i), 3'd7, 1'b1);
    idle(1);
    chk("auto_seq2",  64'(bus.seq_cnt), 64'(2));
    chk("auto_lane0", 64'(bus.demux_out[7:0]),  64'(8'h08));
    chk("auto_lane1", 64'(bus.demux_out[15:8]), 64'(8'h09));

    // Mode switch: auto position survives an explicit burst
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h30 + 8'(i), 3'd0, 1'b1);
    send(8'h61, 3'd6, 1'b0);
    send(8'h62, 3'd6, 1'b0);
    send(8'h77, 3'd0, 1'b1);
    idle(1);
    chk("switch_lane3", 64'(bus.demux_out[24 +: 8]), 64'(8'h77));
    chk("switch_seq4",  64'(bus.seq_cnt), 64'(4));

    // Fill every lane, then assert reset asynchronously with a word pending
    bus.out_ready = 8'h00;
    for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 3'(i), 1'b0);
    idle(1);
    chk("full_valid", 64'(bus.out_valid), 64'(8'hFF));
    bus.data_in = 8'h5A;
    bus.selection_in = 3'd2;
    bus.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",    64'(bus.out_valid),  64'(0));
    chk("arst_seq",      64'(bus.seq_cnt),    64'(0));
    chk("arst_xfer",     64'(bus.xfer_count), 64'(0));
    chk("arst_in_ready", 64'(bus.in_ready),   64'(0));
    chk("arst_data",     bus.demux_out,       64'(0));
    @(posedge clk);
    #1;
    chk("arst_nowrite",  bus.demux_out,       64'(0));
    chk("arst_valid2",   64'(bus.out_valid),  64'(0));
    bus.in_valid = 1'b0;
    bus.out_ready = 8'hFF;
    model_reset();
    rst_n = 1'b1;
    idle(1);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) send(8'(i * 3), 3'd0, 1'b1);
    idle(1);
    chk("sat_xfer", 64'(bus.xfer_count), 64'(CNT_MAX));

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.data_in      = 8'($urandom);
      bus.selection_in = 3'($urandom_range(0, 7));
      bus.auto_mode    = 1'($urandom_range(0, 1));
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.out_ready    = 8'($urandom);
      tick(acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/demux_1to8_reg.md
Name: demux_1to8_reg

Overview:
Clocked 1-to-8 demultiplexer. It is the receive-side counterpart of the team's 8-to-1 mux: one input word stream is steered to one of eight output lanes. Each lane has a 1-deep output register with a valid/ready handshake. Lane selection comes either from an explicit select input or from an internal wrapping sequence counter, which de-interleaves a time-division stream produced by the mux side.

Parameters:
DATA_W, 8, width of each data word and of each output lane
CNT_W, 16, width of the accepted-word counter

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  DATA_W  word to be steered
selection_in  input  3  target lane when auto_mode=0
in_valid  input  1  data_in/selection_in valid this cycle
in_ready  output  1  the currently targeted lane can accept a word this cycle
auto_mode  input  1  1 = target lane comes from internal seq_cnt; 0 = from selection_in
demux_out  output  8*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
out_valid  output  8  per-lane word held
out_ready  input  8  per-lane consumer accept
seq_cnt  output  3  current auto-mode target lane
xfer_count  output  CNT_W  number of accepted input words, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): clears all lane data registers, out_valid=8'h00, seq_cnt=0 and xfer_count=0. in_ready is forced to 0 while rst_n=0.
- sel_eff = auto_mode ? seq_cnt : selection_in. This is combinational.
- lane_free[i] = !out_valid[i] || out_ready[i]. A lane being popped in a cycle can be reloaded in the same cycle.
- in_ready = rst_n && lane_free[sel_eff]. This is combinational and depends on the selection, auto_mode and out_ready. in_ready does not depend on in_valid.
- Accept = in_valid && in_ready. On accept:
  - lane sel_eff data register takes data_in;
  - out_valid[sel_eff] is set to 1;
  - latency is 1 cycle, so the word is visible on demux_out the cycle after accept.
- Pop: out_valid[i] && out_ready[i] clears out_valid[i] at the edge, unless lane i is loaded in the same cycle, in which case valid stays 1 and the data is replaced.
- A lane's data register holds its value while out_valid=0. It is cleared only by reset, never by a pop.
- Unselected lanes are untouched by input activity. Pops on any number of lanes can occur in the same cycle as one accept.
- in_valid with in_ready=0: nothing is written. The producer must hold data_in and the selection until accepted.
- seq_cnt:
  - increments by 1 on each accept while auto_mode=1, wrapping 7->0;
  - holds while auto_mode=0 or when there is no accept.
- Toggling auto_mode takes effect combinationally in the same cycle. seq_cnt is not reset by a mode change.
- xfer_count increments on every accept in either mode. It saturates at 2^CNT_W-1 and does not wrap.
- out_ready on a lane with out_valid=0 is ignored.
- Reset mid-operation immediately drops all held words: out_valid goes to 0 asynchronously and the words are not recovered after reset release.

Test Plan:
- Reset, then explicit mode with all out_ready=1: send 0xA0..0xA7 with selection_in 0..7 → out_valid[i] pulses one cycle after each accept, lane i shows 0xA0+i, in_ready stays 1, xfer_count=8.
- Backpressure: out_ready[3]=0; send 0x11 then 0x22 to lane 3 → first accepted; in_ready=0 while the second is held, lane 3 keeps 0x11. Raise out_ready[3] → 0x22 is accepted in the same cycle as the pop, and out_valid[3] stays 1.
- Auto mode, all ready: send 10 words 0x00..0x09 → lanes 0..7 receive 0x00..0x07, then lanes 0 and 1 are overwritten with 0x08 and 0x09; seq_cnt=2 at the end.
- Mode switch: auto mode, 3 accepts (seq_cnt=3), then explicit mode with 2 accepts to lane 6, then back to auto → the next word lands in lane 3.
- Async reset asserted while out_valid=8'hFF and in_valid=1 → out_valid, seq_cnt and xfer_count are 0 before the next clk edge, in_ready=0 during reset and no write occurs.
- Saturation with CNT_W=4: 20 accepts → xfer_count stops at 15.
